circle_draw: RTL and testbench
==============================

Name: circle_draw

Overview:
- Pixel-generating stage that sits directly upstream of the VGA adapter, alongside the screen-fill engine.
- Draws a circle outline using the midpoint (Bresenham) algorithm at one candidate pixel per clock.
- Drives the adapter's x/y/colour/plot inputs and clips any pixel that falls outside the 160x120 frame.
- A top-level controller (screen clear, then circle) sequences it with a start/done handshake.

Parameters:
- SCREEN_W, 160, frame width; valid x is 0..SCREEN_W-1
- SCREEN_H, 120, frame height; valid y is 0..SCREEN_H-1

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  synchronous, active-high reset
- start  input  1  request; level-sensitive, held high until done is seen
- centre_x  input  8  circle centre x, unsigned
- centre_y  input  7  circle centre y, unsigned
- radius  input  8  radius, unsigned, 0..255
- colour  input  3  pixel colour
- done  output  1  high when the circle is complete; held while start stays high
- vga_x  output  8  pixel x to the VGA adapter
- vga_y  output  7  pixel y to the VGA adapter
- vga_colour  output  3  pixel colour to the VGA adapter
- vga_plot  output  1  write strobe to the VGA adapter

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (any state, including mid-draw): state goes to IDLE; done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- States: IDLE, PLOT, DONE.
- IDLE:
  - On a clk edge with start=1, capture centre_x, centre_y, radius and colour.
  - Load ox=radius, oy=0, crit=1-radius, oct=0, then go to PLOT.
  - Inputs are ignored after capture.
- PLOT: one octant pixel per cycle, oct = 0..7, in this order:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-ox, cy+oy)
  - 3: (cx-oy, cy+ox)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+ox, cy-oy)
  - 7: (cx+oy, cy-ox)
- Arithmetic:
  - Pixel coordinates are computed as 10-bit signed; crit is 11-bit signed.
  - vga_x and vga_y are the low 8 and 7 bits of the computed coordinates.
- Clipping:
  - vga_plot=1 only when 0<=x<=SCREEN_W-1 and 0<=y<=SCREEN_H-1.
  - An off-screen pixel still consumes its cycle with vga_plot=0, so timing is independent of position.
- vga_colour equals the captured colour during PLOT and is 0 otherwise.
- Iteration update, on the edge that ends oct=7:
  - oy <= oy+1.
  - If crit<=0: crit <= crit+2*(oy+1)+1.
  - Else: ox <= ox-1 and crit <= crit+2*((oy+1)-(ox-1))+1.
  - If the updated oy > updated ox, go to DONE; otherwise oct <= 0 and stay in PLOT.
- Latency: start is sampled at edge k; pixel 0 is presented in the cycle after k. PLOT lasts exactly 8*N cycles, where N is the iteration count. done rises in the cycle after the last PLOT cycle.
- Duplicate pixels are re-plotted, not suppressed: radius 0 plots the centre 8 times, and the octant diagonal pixels repeat.
- DONE:
  - done=1 and vga_plot=0.
  - Stay while start=1; no automatic restart.
  - When start=0, go to IDLE with done=0 the following cycle.
- start dropping during PLOT has no effect; the draw completes.
- vga_plot never asserts outside PLOT.

Test Plan:
- Reset behaviour: assert rst for 3 cycles, then release with start=0. All outputs stay 0 in IDLE. Then assert rst during PLOT (cycle 5 of a radius-20 draw): next cycle vga_plot=0 and done=0; the block stays IDLE until start is seen again.
- Radius 0, centre (80,60), colour 3'b010: exactly 8 cycles with vga_plot=1, all at (80,60) with colour 2. done=1 on cycle 9 after the start sample.
- Radius 3, centre (80,60): N=3, 24 PLOT cycles. Iteration (ox,oy) pairs are (3,0), (3,1), (2,2). First iteration emits (83,60), (80,63), (77,60), (80,63), (77,60), (80,57), (83,60), (80,57). Check against a reference-model scoreboard.
- Clipping, centre (0,0), radius 10: only pixels with x>=0 and y>=0 have vga_plot=1. For example, oct 4 of iteration 0 gives (-10,0) with vga_plot=0. Total PLOT cycles equal the unclipped count (8*N). No pixel with x>159 or y>119 is ever strobed.
- Large-radius wrap guard, centre (159,119), radius 255: no vga_plot=1 pixel appears outside the frame (checks the signed compare, not a truncated one). done asserts.
- Handshake: hold start high after done. done stays 1 for 20 cycles with no new PLOT. Drop start: done=0 the next cycle. Reassert start with radius 1: 16 PLOT cycles, then done.

Source files
------------

// File: rtl/circle_draw.sv
// circle_draw: midpoint circle rasteriser feeding the VGA adapter.
// Emits one candidate outline pixel per clock (eight octant reflections per
// iteration) and clips anything outside the SCREEN_W x SCREEN_H frame.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       level request, held until done is seen
//   centre_x/y  circle centre (captured when leaving IDLE)
//   radius      circle radius 0..255 (captured)
//   colour      pixel colour (captured)
//   done        circle complete; held while start stays high
//   vga_x/y     pixel coordinate to the adapter (low bits of the signed result)
//   vga_colour  captured colour while plotting, 0 otherwise
//   vga_plot    adapter write strobe, only for on-screen pixels
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// PLOT  | emitting octant pixel oct of the current (ox, oy) iteration
// DONE  | circle finished; done held until start drops
module circle_draw #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  input  logic [2:0] colour,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

  localparam logic signed [9:0] X_MAX = 10'(SCREEN_W - 1);
  localparam logic signed [9:0] Y_MAX = 10'(SCREEN_H - 1);

  state_t state, state_next;

  logic [7:0]         cx, cx_next;
  logic [6:0]         cy, cy_next;
  logic [2:0]         col, col_next;
  logic signed [9:0]  ox, ox_next;
  logic signed [9:0]  oy, oy_next;
  logic signed [10:0] crit, crit_next;
  logic [2:0]         oct, oct_next;

  logic signed [9:0]  cx_s, cy_s, dx, dy, px, py;
  logic signed [9:0]  oy_inc, ox_dec, diff;
  logic signed [10:0] crit_lo, crit_hi;
  logic               on_screen;

  assign cx_s = $signed({2'b00, cx});
  assign cy_s = $signed({3'b000, cy});

  // Octant reflection of the current (ox, oy) offset.
  always_comb begin
    dx = ox;
    dy = oy;
    case (oct)
      3'd0: begin dx =  ox; dy =  oy; end
      3'd1: begin dx =  oy; dy =  ox; end
      3'd2: begin dx = -ox; dy =  oy; end
      3'd3: begin dx = -oy; dy =  ox; end
      3'd4: begin dx = -ox; dy = -oy; end
      3'd5: begin dx = -oy; dy = -ox; end
      3'd6: begin dx =  ox; dy = -oy; end
      default: begin dx = oy; dy = -ox; end
    endcase
  end

  assign px = cx_s + dx;
  assign py = cy_s + dy;

  // Signed compare: negative or wrapped coordinates must never strobe.
  assign on_screen = (px >= 10'sd0) && (px <= X_MAX) &&
                     (py >= 10'sd0) && (py <= Y_MAX);

  assign oy_inc  = oy + 10'sd1;
  assign ox_dec  = ox - 10'sd1;
  assign diff    = oy_inc - ox_dec;
  assign crit_lo = crit + $signed({oy_inc, 1'b0}) + 11'sd1;
  assign crit_hi = crit + $signed({diff, 1'b0}) + 11'sd1;

  always_comb begin
    state_next = state;
    cx_next    = cx;
    cy_next    = cy;
    col_next   = col;
    ox_next    = ox;
    oy_next    = oy;
    crit_next  = crit;
    oct_next   = oct;
    done       = 1'b0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    vga_plot   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cx_next    = centre_x;
          cy_next    = centre_y;
          col_next   = colour;
          ox_next    = $signed({2'b00, radius});
          oy_next    = 10'sd0;
          crit_next  = 11'sd1 - $signed({3'b000, radius});
          oct_next   = 3'd0;
          state_next = PLOT;
        end
      end
      PLOT: begin
        vga_x      = px[7:0];
        vga_y      = py[6:0];
        vga_colour = col;
        vga_plot   = on_screen;
        if (oct == 3'd7) begin
          oy_next = oy_inc;
          if (crit <= 11'sd0) begin
            crit_next = crit_lo;
          end else begin
            ox_next   = ox_dec;
            crit_next = crit_hi;
          end
          if (oy_inc > ox_next) begin
            state_next = DONE;
          end
          oct_next = 3'd0;
        end else begin
          oct_next = oct + 3'd1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cx    <= 8'd0;
      cy    <= 7'd0;
      col   <= 3'd0;
      ox    <= 10'sd0;
      oy    <= 10'sd0;
      crit  <= 11'sd0;
      oct   <= 3'd0;
    end else begin
      state <= state_next;
      cx    <= cx_next;
      cy    <= cy_next;
      col   <= col_next;
      ox    <= ox_next;
      oy    <= oy_next;
      crit  <= crit_next;
      oct   <= oct_next;
    end
  end

endmodule

// File: tb/tb_circle_draw.sv
// Bench for circle_draw: a pixel-list model of the midpoint circle, a
// per-cycle output compare, and directed draws with hand-computed timing.
module tb_circle_draw;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic [2:0] colour;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  always #10 clk = ~clk;

  circle_draw dut (
    .clk(clk), .rst(rst), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
    .done(done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot)
  );

  typedef struct {
    int x;
    int y;
    bit plot;
  } pix_t;

  pix_t gen_q[$];
  pix_t m_q[$];
  logic [2:0] m_col;
  int m_phase = 0;    // 0 idle, 1 drawing, 2 finished
  bit armed = 1'b0;
  int passed = 0;
  int total = 0;
  int plot_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Full outline pixel list for a circle, in emission order.
  function automatic void gen(input int cx, input int cy, input int r);
    int ox;
    int oy;
    int crit;
    int xs[8];
    int ys[8];
    bit go;
    pix_t p;
    gen_q.delete();
    ox = r;
    oy = 0;
    crit = 1 - r;
    go = 1'b1;
    while (go) begin
      xs = '{cx+ox, cx+oy, cx-ox, cx-oy, cx-ox, cx-oy, cx+ox, cx+oy};
      ys = '{cy+oy, cy+ox, cy+oy, cy+ox, cy-oy, cy-ox, cy-oy, cy-ox};
      for (int k = 0; k < 8; k++) begin
        p.x = xs[k];
        p.y = ys[k];
        p.plot = (xs[k] >= 0) && (xs[k] < 160) && (ys[k] >= 0) && (ys[k] < 120);
        gen_q.push_back(p);
      end
      oy++;
      if (crit <= 0) crit += 2*oy + 1;
      else begin
        ox--;
        crit += 2*(oy - ox) + 1;
      end
      go = (oy <= ox);
    end
  endfunction

  // Model: what the outputs should show during the cycle after each edge.
  always @(posedge clk) begin
    armed = 1'b1;
    if (rst) begin
      m_q.delete();
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          gen(int'(centre_x), int'(centre_y), int'(radius));
          m_q = gen_q;
          m_col = colour;
          m_phase = 1;
        end
        1: begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_phase = 2;
        end
        default: if (!start) m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (armed) begin
      if (m_phase == 1) begin
        chk("plot", int'(vga_plot), int'(m_q[0].plot));
        chk("x", int'(vga_x), m_q[0].x & 255);
        chk("y", int'(vga_y), m_q[0].y & 127);
        chk("colour", int'(vga_colour), int'(m_col));
        chk("done_in_plot", int'(done), 0);
        if (vga_plot) plot_seen++;
      end else begin
        chk("plot_quiet", int'(vga_plot), 0);
        chk("done_state", int'(done), (m_phase == 2) ? 1 : 0);
        chk("x_quiet", int'(vga_x), 0);
        chk("y_quiet", int'(vga_y), 0);
        chk("colour_quiet", int'(vga_colour), 0);
      end
      if (vga_plot)
        chk("in_frame", int'((vga_x < 8'd160) && (vga_y < 7'd120)), 1);
    end
  end

  task automatic draw(input int cx, input int cy, input int r, input int col,
                      input int hold, output int cyc);
    @(negedge clk);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius = 8'(r);
    colour = 3'(col);
    plot_seen = 0;
    start = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", int'(done === 1'b1), 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold", int'(done), 1);
      chk("hold_no_plot", int'(vga_plot), 0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_drop", int'(done), 0);
  endtask

  int cyc;
  int n_plot;
  int n_all;
  int exp_x[8];
  int exp_y[8];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    centre_x = '0;
    centre_y = '0;
    radius = '0;
    colour = '0;

    // Pin the model with hand-derived values.
    gen(80, 60, 0);
    chk("model_r0_len", gen_q.size(), 8);
    chk("model_r0_x", gen_q[5].x, 80);
    chk("model_r0_y", gen_q[7].y, 60);
    gen(80, 60, 3);
    chk("model_r3_len", gen_q.size(), 24);
    exp_x = '{83, 80, 77, 80, 77, 80, 83, 80};
    exp_y = '{60, 63, 60, 63, 60, 57, 60, 57};
    for (int k = 0; k < 8; k++) begin
      chk("model_r3_it0_x", gen_q[k].x, exp_x[k]);
      chk("model_r3_it0_y", gen_q[k].y, exp_y[k]);
    end
    chk("model_r3_it1_x", gen_q[8].x, 83);
    chk("model_r3_it1_y", gen_q[8].y, 61);
    chk("model_r3_it2_x", gen_q[16].x, 82);
    chk("model_r3_it2_y", gen_q[16].y, 62);
    gen(0, 0, 10);
    chk("model_clip_x", gen_q[4].x, -10);
    chk("model_clip_plot", int'(gen_q[4].plot), 0);
    gen(80, 60, 1);
    chk("model_r1_len", gen_q.size(), 16);

    // Reset, then idle with start low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_done", int'(done), 0);
    chk("idle_plot", int'(vga_plot), 0);

    // Reset in the middle of a radius-20 draw.
    @(negedge clk);
    centre_x = 8'd80;
    centre_y = 7'd60;
    radius = 8'd20;
    colour = 3'd1;
    start = 1'b1;
    repeat (5) @(negedge clk);
    chk("midplot_active", int'(vga_plot), 1);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_done", int'(done), 0);
    repeat (5) @(negedge clk);
    chk("rst_stays_idle", int'(vga_plot), 0);

    // Radius 0: centre plotted eight times, done on cycle 9.
    draw(80, 60, 0, 2, 0, cyc);
    chk("r0_done_cycle", cyc, 9);
    chk("r0_plots", plot_seen, 8);

    // Radius 3 with a 20-cycle hold after done.
    draw(80, 60, 3, 5, 20, cyc);
    chk("r3_done_cycle", cyc, 25);
    chk("r3_plots", plot_seen, 24);

    // Reassert with radius 1.
    draw(80, 60, 1, 6, 0, cyc);
    chk("r1_done_cycle", cyc, 17);
    chk("r1_plots", plot_seen, 16);

    // Clipping at the origin.
    gen(0, 0, 10);
    n_all = gen_q.size();
    n_plot = 0;
    foreach (gen_q[i]) if (gen_q[i].plot) n_plot++;
    draw(0, 0, 10, 7, 0, cyc);
    chk("clip_done_cycle", cyc, n_all + 1);
    chk("clip_plots", plot_seen, n_plot);

    // Large radius from the bottom-right corner.
    gen(159, 119, 255);
    n_all = gen_q.size();
    n_plot = 0;
    foreach (gen_q[i]) if (gen_q[i].plot) n_plot++;
    draw(159, 119, 255, 3, 0, cyc);
    chk("wrap_done_cycle", cyc, n_all + 1);
    chk("wrap_plots", plot_seen, n_plot);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
